// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Widths, iteration count and FSM state encoding for the BCD <-> binary
//   converters, plus a digit-legality helper.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

   localparam int BCD_W  = 12;   // three packed BCD digits
   localparam int BIN_W  = 10;   // 0..999 fits in 10 bits
   localparam int N_ITER = 12;   // one shift per BCD input bit
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

   // High if any of the three nibbles holds a non-decimal code (A..F).
   function automatic logic bcd_invalid(input logic [BCD_W-1:0] v);
      return (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_if
//   Request/result bundle of the BCD-to-binary converter.
//   en, data_bcd            : requester -> converter
//   data_bin, data_bin_valid,
//   bcd_err, busy           : converter -> requester
//   master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_to_bin_if;
   import bcd_pkg::*;

   logic             en;
   logic [BCD_W-1:0] data_bcd;
   logic [BIN_W-1:0] data_bin;
   logic             data_bin_valid;
   logic             bcd_err;
   logic             busy;

   modport master (
      output en, data_bcd,
      input  data_bin, data_bin_valid, bcd_err, busy
   );

   modport slave (
      input  en, data_bcd,
      output data_bin, data_bin_valid, bcd_err, busy
   );

endinterface

// File: rtl/bcd_nibble_sub3.sv
// -----------------------------------------------------------------------------
// bcd_nibble_sub3
//   Correction step of the reverse double-dabble: after a right shift a BCD
//   nibble >= 8 carried a "ten" that must become a binary 8, so subtract 3.
//   nib_in  [3:0] : shifted nibble
//   nib_out [3:0] : corrected nibble
// -----------------------------------------------------------------------------
module bcd_nibble_sub3 (
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out
);

   always_comb begin
      nib_out = nib_in;
      if (nib_in >= 4'd8) begin
         nib_out = nib_in - 4'd3;
      end
   end

endmodule

// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
//   Serial 3-digit BCD to 10-bit binary converter (reverse double-dabble),
//   fixed 13-cycle latency from the start edge to the registered result.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_to_bin_if.slave (en, data_bcd in; data_bin, data_bin_valid,
//           bcd_err, busy out)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for en; latches the BCD word on start
//   ST_SHIFT | 12 shift/correct iterations
//   ST_DONE  | registers result, error and one-cycle valid pulse
// -----------------------------------------------------------------------------
module bcd_to_bin
   import bcd_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   bcd_to_bin_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

   state_t             state, state_nxt;
   logic [BCD_W-1:0]   bcd_buf, bin_buf;
   logic [CNT_W-1:0]   cnt;
   logic               err_flag;
   logic [BIN_W-1:0]   data_bin_r;
   logic               valid_r, err_r;

   logic [BCD_W-1:0]   bcd_shr, bcd_adj, bin_shr;

   // bcd_buf[0] falls into the top of bin_buf on every shift.
   assign bcd_shr = {1'b0, bcd_buf[BCD_W-1:1]};
   assign bin_shr = {bcd_buf[0], bin_buf[BCD_W-1:1]};

   bcd_nibble_sub3 u_sub3_hun (.nib_in(bcd_shr[11:8]), .nib_out(bcd_adj[11:8]));
   bcd_nibble_sub3 u_sub3_ten (.nib_in(bcd_shr[7:4]),  .nib_out(bcd_adj[7:4]));
   bcd_nibble_sub3 u_sub3_uni (.nib_in(bcd_shr[3:0]),  .nib_out(bcd_adj[3:0]));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.en) state_nxt = ST_SHIFT;
         ST_SHIFT: if (cnt == LAST_ITER) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_buf    <= '0;
         bin_buf    <= '0;
         cnt        <= '0;
         err_flag   <= 1'b0;
         data_bin_r <= '0;
         valid_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         valid_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.en) begin
                  bcd_buf  <= bus.data_bcd;
                  bin_buf  <= '0;
                  cnt      <= '0;
                  err_flag <= bcd_invalid(bus.data_bcd);
               end
            end
            ST_SHIFT: begin
               bcd_buf <= bcd_adj;
               bin_buf <= bin_shr;
               cnt     <= cnt + 1'b1;
            end
            ST_DONE: begin
               // After 12 shifts the whole BCD word has moved into bin_buf;
               // the value is < 1000, so it sits entirely in the low 10 bits.
               data_bin_r <= err_flag ? '0 : bin_buf[BIN_W-1:0];
               valid_r    <= 1'b1;
               err_r      <= err_flag;
            end
            default: ;
         endcase
      end
   end

   assign bus.data_bin       = data_bin_r;
   assign bus.data_bin_valid = valid_r;
   assign bus.bcd_err        = err_r;
   assign bus.busy           = (state != ST_IDLE);

endmodule
